mbinit_val_train_ctrl: RTL and testbench
========================================

Name: mbinit_val_train_ctrl

Overview:
- Parametrised sideband-handshake controller for the MBINIT valid/lane validation step; successor to the fixed 4-bit, single-result REPAIRVAL controller.
- Runs init -> pattern -> result -> done request/response exchanges, evaluates a per-lane partner result vector against a minimum-lane threshold, retries on failure, and enforces response timeouts.
- Sits between the MBINIT sequencer (start/end/error) and the sideband TX/RX message interface.

Parameters:
- NUM_LANES, 16, number of lanes reported in result payload.
- MIN_LANES, 16, minimum passing lanes for success (1..NUM_LANES).
- MAX_RETRY, 2, pattern/result retries after a failing evaluation.
- TIMEOUT_CYCLES, 1024, cycles allowed in any response-wait state; 0 disables the timeout.
- MSG_W, 4, sideband message code width (codes 1..6 zero-extended).

Ports:
- CLK  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  level; previous MBINIT step ended, stay high for duration
- i_Busy_SideBand  in  1  sideband TX busy
- i_falling_edge_busy  in  1  one-cycle pulse, TX accepted/finished message
- i_Rx_SbMessage  in  MSG_W  received message code
- i_msg_valid  in  1  qualifies i_Rx_SbMessage / i_Rx_Payload
- i_Rx_Payload  in  NUM_LANES  per-lane pass bits carried by result_resp
- i_pattern_done  in  1  pattern generator finished
- o_TX_SbMessage  out  MSG_W  message code to send
- o_ValidOutDatat_Module  out  1  TX request valid
- o_pattern_en  out  1  enable pattern generator
- o_module_end  out  1  step completed successfully
- o_train_error_req  out  1  training error request
- o_lane_mask  out  NUM_LANES  last latched partner lane result
- o_retry_cnt  out  $clog2(MAX_RETRY+1)  retries consumed

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter and retry counter 0.
- Codes: init_req 1, init_resp 2, result_req 3, result_resp 4, done_req 5, done_resp 6.
- Outputs are registered and decoded from next_state, so they are valid in exactly the cycles current_state equals the decoding state; default 0.
- States and transitions:
  - IDLE: i_start && !busy -> SEND_INIT; retry_cnt cleared on leaving IDLE.
  - SEND_INIT: valid=1, msg=1; i_falling_edge_busy -> WAIT_INIT_RESP.
  - WAIT_INIT_RESP: valid msg 2 -> RUN_PATTERN.
  - RUN_PATTERN: o_pattern_en=1; i_pattern_done -> WAIT_BUSY_RESULT.
  - WAIT_BUSY_RESULT: !busy -> SEND_RESULT.
  - SEND_RESULT: valid=1, msg=3; i_falling_edge_busy -> WAIT_RESULT_RESP.
  - WAIT_RESULT_RESP: valid msg 4 -> latch i_Rx_Payload into o_lane_mask, go to EVALUATE.
  - EVALUATE (1 cycle): popcount(o_lane_mask) >= MIN_LANES -> WAIT_BUSY_DONE. Otherwise, if retry_cnt < MAX_RETRY, increment retry_cnt and go to WAIT_BUSY_INIT (!busy -> SEND_INIT). Otherwise go to ERROR.
  - WAIT_BUSY_DONE: !busy -> SEND_DONE.
  - SEND_DONE: valid=1, msg=5; i_falling_edge_busy -> WAIT_DONE_RESP.
  - WAIT_DONE_RESP: valid msg 6 -> COMPLETE.
  - COMPLETE: o_module_end=1 held; !i_start -> IDLE.
  - ERROR: o_train_error_req=1 held; !i_start -> IDLE.
- Wait states accept only their expected code; other valid codes are ignored and the state holds.
- Timeout: the counter clears on entry to each WAIT_*_RESP state and increments each cycle while in it. If it reaches TIMEOUT_CYCLES-1 without the expected message -> ERROR. An expected message in that same cycle wins over the timeout.
- Abort: i_start low in any state other than IDLE/COMPLETE/ERROR -> IDLE next cycle, with all outputs 0; this has highest priority. o_lane_mask and o_retry_cnt hold their values until the next start.
- popcount width is $clog2(NUM_LANES+1); the comparison is unsigned.
- Reset mid-operation returns immediately to reset values.
- Undefined state encodings -> IDLE.

Test Plan:
- Nominal: i_start=1, responses 2/4/6 each 3 cycles after the TX busy falling edge, payload 16'hFFFF -> TX codes 1,3,5 in order, o_module_end=1, o_retry_cnt=0, o_lane_mask=FFFF.
- Retry pass: first payload 16'h7FFF, second 16'hFFFF -> second init_req issued, o_retry_cnt=1, o_module_end=1.
- Retry exhausted: three payloads of 16'h00FF (MAX_RETRY=2) -> o_train_error_req=1 after the third EVALUATE, o_retry_cnt=2; i_start low -> IDLE with outputs 0.
- Timeout: TIMEOUT_CYCLES=16, no init_resp -> o_train_error_req rises exactly 16 cycles after WAIT_INIT_RESP entry; repeat with init_resp in cycle 15 -> no error.
- Unexpected code: code 6 sent during WAIT_RESULT_RESP -> ignored, state holds; a later code 4 proceeds normally.
- Abort: i_start dropped during RUN_PATTERN -> o_pattern_en=0 next cycle, state IDLE, no end or error pulse; async reset asserted mid-SEND_RESULT -> all outputs 0 immediately.

Source files
------------

// File: rtl/mbinit_val_train_ctrl_if.sv
// -----------------------------------------------------------------------------
// mbinit_val_train_ctrl_if
//
// Sideband TX/RX message bundle between the MBINIT valid-train controller and
// the sideband message block.
//
// Signals (names are from the controller's point of view):
//   i_Busy_SideBand        sideband TX busy
//   i_falling_edge_busy    one-cycle pulse, TX accepted/finished the message
//   i_Rx_SbMessage         received message code
//   i_msg_valid            qualifies i_Rx_SbMessage / i_Rx_Payload
//   i_Rx_Payload           per-lane pass bits carried by result_resp
//   o_TX_SbMessage         message code to send
//   o_ValidOutDatat_Module TX request valid
//
// Modports:
//   master  - the controller (drives the TX request, consumes RX)
//   slave   - the sideband block (consumes the TX request, drives RX)
// -----------------------------------------------------------------------------
interface mbinit_val_train_ctrl_if #(
    parameter int MSG_W     = 4,
    parameter int NUM_LANES = 16
);
    logic                 i_Busy_SideBand;
    logic                 i_falling_edge_busy;
    logic [MSG_W-1:0]     i_Rx_SbMessage;
    logic                 i_msg_valid;
    logic [NUM_LANES-1:0] i_Rx_Payload;
    logic [MSG_W-1:0]     o_TX_SbMessage;
    logic                 o_ValidOutDatat_Module;

    modport master (
        input  i_Busy_SideBand,
        input  i_falling_edge_busy,
        input  i_Rx_SbMessage,
        input  i_msg_valid,
        input  i_Rx_Payload,
        output o_TX_SbMessage,
        output o_ValidOutDatat_Module
    );

    modport slave (
        output i_Busy_SideBand,
        output i_falling_edge_busy,
        output i_Rx_SbMessage,
        output i_msg_valid,
        output i_Rx_Payload,
        input  o_TX_SbMessage,
        input  o_ValidOutDatat_Module
    );
endinterface

// File: rtl/mbinit_val_train_ctrl.sv
// -----------------------------------------------------------------------------
// mbinit_val_train_ctrl
//
// Sideband handshake controller for the MBINIT valid/lane validation step.
// Runs the init -> pattern -> result -> done request/response exchanges,
// checks the partner's per-lane result vector against a minimum passing-lane
// count, retries the pattern/result exchange on a failing evaluation and
// bounds every response wait with a timeout.
//
// Ports:
//   CLK               clock
//   rst_n             asynchronous active-low reset
//   i_start           level, high for the whole step; low aborts to IDLE
//   i_pattern_done    pattern generator finished
//   sb                sideband TX/RX bundle (master modport)
//   o_pattern_en      enable pattern generator
//   o_module_end      step completed successfully (held until i_start low)
//   o_train_error_req training error request (held until i_start low)
//   o_lane_mask       last latched partner lane result
//   o_retry_cnt       retries consumed in the current step
//   o_state           current FSM state (debug/observability)
//
// TX handshake: the controller raises o_ValidOutDatat_Module with a stable
// o_TX_SbMessage and holds both until the sideband block pulses
// i_falling_edge_busy, which marks the message as taken; the request drops in
// the following cycle. RX messages are single-cycle, qualified by i_msg_valid.
//
// All control outputs are registered and decoded from the next state, so
// each one is high in exactly the cycles the FSM sits in its decoding state.
// -----------------------------------------------------------------------------
module mbinit_val_train_ctrl #(
    parameter int NUM_LANES      = 16,
    parameter int MIN_LANES      = 16,
    parameter int MAX_RETRY      = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MSG_W          = 4,
    localparam int RETRY_W       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic                   i_pattern_done,
    mbinit_val_train_ctrl_if.master sb,
    output logic                   o_pattern_en,
    output logic                   o_module_end,
    output logic                   o_train_error_req,
    output logic [NUM_LANES-1:0]   o_lane_mask,
    output logic [RETRY_W-1:0]     o_retry_cnt,
    output logic [3:0]             o_state
);

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int PC_W  = $clog2(NUM_LANES + 1);
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TO_LAST_INT);
    localparam logic TO_ENABLE = (TIMEOUT_CYCLES != 0);

    localparam logic [MSG_W-1:0] MSG_INIT_REQ    = MSG_W'(1);
    localparam logic [MSG_W-1:0] MSG_INIT_RESP   = MSG_W'(2);
    localparam logic [MSG_W-1:0] MSG_RESULT_REQ  = MSG_W'(3);
    localparam logic [MSG_W-1:0] MSG_RESULT_RESP = MSG_W'(4);
    localparam logic [MSG_W-1:0] MSG_DONE_REQ    = MSG_W'(5);
    localparam logic [MSG_W-1:0] MSG_DONE_RESP   = MSG_W'(6);

    localparam logic [PC_W-1:0]    MIN_PASS  = PC_W'(MIN_LANES);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE             = 4'd0,
        S_SEND_INIT        = 4'd1,
        S_WAIT_INIT_RESP   = 4'd2,
        S_RUN_PATTERN      = 4'd3,
        S_WAIT_BUSY_RESULT = 4'd4,
        S_SEND_RESULT      = 4'd5,
        S_WAIT_RESULT_RESP = 4'd6,
        S_EVALUATE         = 4'd7,
        S_WAIT_BUSY_INIT   = 4'd8,
        S_WAIT_BUSY_DONE   = 4'd9,
        S_SEND_DONE        = 4'd10,
        S_WAIT_DONE_RESP   = 4'd11,
        S_COMPLETE         = 4'd12,
        S_ERROR            = 4'd13
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t               state_q;
    state_t               state_d;
    logic [TMR_W-1:0]     timer_q;
    logic [RETRY_W-1:0]   retry_q;
    logic [NUM_LANES-1:0] lane_mask_q;
    logic [PC_W-1:0]      pass_cnt;

    logic in_wait;
    logic timeout_hit;
    logic abort;
    logic start_step;
    logic retry_inc;
    logic mask_load;
    logic lanes_ok;
    logic init_resp_hit;
    logic result_resp_hit;
    logic done_resp_hit;

    logic             valid_d;
    logic [MSG_W-1:0] msg_d;
    logic             pat_en_d;
    logic             end_d;
    logic             err_d;

    // ------------------------------------------------------------------
    // Receive decode: a wait state only reacts to its own response code.
    // ------------------------------------------------------------------
    assign init_resp_hit   = sb.i_msg_valid && (sb.i_Rx_SbMessage == MSG_INIT_RESP);
    assign result_resp_hit = sb.i_msg_valid && (sb.i_Rx_SbMessage == MSG_RESULT_RESP);
    assign done_resp_hit   = sb.i_msg_valid && (sb.i_Rx_SbMessage == MSG_DONE_RESP);

    assign in_wait = (state_q == S_WAIT_INIT_RESP)   ||
                     (state_q == S_WAIT_RESULT_RESP) ||
                     (state_q == S_WAIT_DONE_RESP);

    assign timeout_hit = TO_ENABLE && in_wait && (timer_q == TO_LAST);

    // Dropping i_start abandons the step from any active state. COMPLETE
    // and ERROR handle !i_start themselves as their normal exit.
    assign abort = !i_start &&
                   (state_q != S_IDLE) &&
                   (state_q != S_COMPLETE) &&
                   (state_q != S_ERROR);

    // ------------------------------------------------------------------
    // Lane evaluation on the latched partner result
    // ------------------------------------------------------------------
    always_comb begin
        pass_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            pass_cnt = pass_cnt + PC_W'(lane_mask_q[i]);
        end
    end

    assign lanes_ok = (pass_cnt >= MIN_PASS);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        mask_load = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start && !sb.i_Busy_SideBand) begin
                        state_d = S_SEND_INIT;
                    end
                end
                S_SEND_INIT: begin
                    if (sb.i_falling_edge_busy) begin
                        state_d = S_WAIT_INIT_RESP;
                    end
                end
                // The expected response is checked before the timeout so a
                // response arriving in the last allowed cycle still counts.
                S_WAIT_INIT_RESP: begin
                    if (init_resp_hit) begin
                        state_d = S_RUN_PATTERN;
                    end else if (timeout_hit) begin
                        state_d = S_ERROR;
                    end
                end
                S_RUN_PATTERN: begin
                    if (i_pattern_done) begin
                        state_d = S_WAIT_BUSY_RESULT;
                    end
                end
                S_WAIT_BUSY_RESULT: begin
                    if (!sb.i_Busy_SideBand) begin
                        state_d = S_SEND_RESULT;
                    end
                end
                S_SEND_RESULT: begin
                    if (sb.i_falling_edge_busy) begin
                        state_d = S_WAIT_RESULT_RESP;
                    end
                end
                S_WAIT_RESULT_RESP: begin
                    if (result_resp_hit) begin
                        mask_load = 1'b1;
                        state_d   = S_EVALUATE;
                    end else if (timeout_hit) begin
                        state_d = S_ERROR;
                    end
                end
                S_EVALUATE: begin
                    if (lanes_ok) begin
                        state_d = S_WAIT_BUSY_DONE;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_inc = 1'b1;
                        state_d   = S_WAIT_BUSY_INIT;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
                S_WAIT_BUSY_INIT: begin
                    if (!sb.i_Busy_SideBand) begin
                        state_d = S_SEND_INIT;
                    end
                end
                S_WAIT_BUSY_DONE: begin
                    if (!sb.i_Busy_SideBand) begin
                        state_d = S_SEND_DONE;
                    end
                end
                S_SEND_DONE: begin
                    if (sb.i_falling_edge_busy) begin
                        state_d = S_WAIT_DONE_RESP;
                    end
                end
                S_WAIT_DONE_RESP: begin
                    if (done_resp_hit) begin
                        state_d = S_COMPLETE;
                    end else if (timeout_hit) begin
                        state_d = S_ERROR;
                    end
                end
                S_COMPLETE: begin
                    if (!i_start) begin
                        state_d = S_IDLE;
                    end
                end
                S_ERROR: begin
                    if (!i_start) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign start_step = (state_q == S_IDLE) && (state_d == S_SEND_INIT);

    // ------------------------------------------------------------------
    // Response-wait timer: restarts from zero on every state change, so it
    // is zero in the first cycle of each wait state and counts while there.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (state_d != state_q) begin
            timer_q <= '0;
        end else if (in_wait) begin
            timer_q <= timer_q + TMR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Retry counter and lane result. Both survive an abort so the sequencer
    // can inspect them; a new step clears them.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= '0;
        end else if (start_step) begin
            retry_q <= '0;
        end else if (retry_inc) begin
            retry_q <= retry_q + RETRY_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            lane_mask_q <= '0;
        end else if (start_step) begin
            lane_mask_q <= '0;
        end else if (mask_load) begin
            lane_mask_q <= sb.i_Rx_Payload;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, registered below
    // ------------------------------------------------------------------
    always_comb begin
        valid_d  = 1'b0;
        msg_d    = '0;
        pat_en_d = 1'b0;
        end_d    = 1'b0;
        err_d    = 1'b0;
        case (state_d)
            S_SEND_INIT: begin
                valid_d = 1'b1;
                msg_d   = MSG_INIT_REQ;
            end
            S_SEND_RESULT: begin
                valid_d = 1'b1;
                msg_d   = MSG_RESULT_REQ;
            end
            S_SEND_DONE: begin
                valid_d = 1'b1;
                msg_d   = MSG_DONE_REQ;
            end
            S_RUN_PATTERN: pat_en_d = 1'b1;
            S_COMPLETE:    end_d    = 1'b1;
            S_ERROR:       err_d    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sb.o_ValidOutDatat_Module <= 1'b0;
            sb.o_TX_SbMessage         <= '0;
            o_pattern_en              <= 1'b0;
            o_module_end              <= 1'b0;
            o_train_error_req         <= 1'b0;
        end else begin
            sb.o_ValidOutDatat_Module <= valid_d;
            sb.o_TX_SbMessage         <= msg_d;
            o_pattern_en              <= pat_en_d;
            o_module_end              <= end_d;
            o_train_error_req         <= err_d;
        end
    end

    assign o_lane_mask = lane_mask_q;
    assign o_retry_cnt = retry_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_mbinit_val_train_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mbinit_val_train_ctrl
//
// Bench for mbinit_val_train_ctrl with TIMEOUT_CYCLES=16, MAX_RETRY=2,
// NUM_LANES=MIN_LANES=16. A small sideband model answers every TX request:
// busy for two cycles, a falling-edge pulse, then the matching response after
// resp_delay cycles. Expected TX codes are queued per scenario and popped
// whenever the DUT raises a new TX request.
// -----------------------------------------------------------------------------
module tb_mbinit_val_train_ctrl;
    localparam int NUM_LANES = 16;
    localparam int MSG_W     = 4;

    // FSM encodings observed through o_state
    localparam logic [3:0] ST_IDLE        = 4'd0;
    localparam logic [3:0] ST_WAIT_INIT   = 4'd2;
    localparam logic [3:0] ST_WAIT_RESULT = 4'd6;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 i_start        = 1'b0;
    logic                 i_pattern_done = 1'b0;
    logic                 o_pattern_en;
    logic                 o_module_end;
    logic                 o_train_error_req;
    logic [NUM_LANES-1:0] o_lane_mask;
    logic [1:0]           o_retry_cnt;
    logic [3:0]           o_state;

    mbinit_val_train_ctrl_if #(.MSG_W(MSG_W), .NUM_LANES(NUM_LANES)) sb ();

    mbinit_val_train_ctrl #(
        .NUM_LANES(NUM_LANES),
        .MIN_LANES(16),
        .MAX_RETRY(2),
        .TIMEOUT_CYCLES(16),
        .MSG_W(MSG_W)
    ) dut (
        .CLK               (clk),
        .rst_n             (rst_n),
        .i_start           (i_start),
        .i_pattern_done    (i_pattern_done),
        .sb                (sb),
        .o_pattern_en      (o_pattern_en),
        .o_module_end      (o_module_end),
        .o_train_error_req (o_train_error_req),
        .o_lane_mask       (o_lane_mask),
        .o_retry_cnt       (o_retry_cnt),
        .o_state           (o_state)
    );

    // ---------------- scoreboard / counters ----------------
    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;
    logic [MSG_W-1:0]     exp_q[$];
    logic [NUM_LANES-1:0] pay_q[$];

    // ---------------- sideband model state ----------------
    bit         prev_valid;
    int         busy_cnt;
    int         resp_cnt;
    int         resp_delay;
    int         pat_cnt;
    int         fall_cyc;
    int         wrong_cyc;
    logic [3:0] req_code;
    logic [3:0] resp_code;
    bit         drop_init_resp;
    bit         inject_wrong;
    bit         hold_pattern;

    task automatic reset_model();
        prev_valid      = 1'b0;
        busy_cnt        = 0;
        resp_cnt        = 0;
        resp_delay      = 3;
        pat_cnt         = 0;
        fall_cyc        = 0;
        wrong_cyc       = 0;
        req_code        = '0;
        resp_code       = '0;
        drop_init_resp  = 1'b0;
        inject_wrong    = 1'b0;
        hold_pattern    = 1'b0;
        exp_q.delete();
        pay_q.delete();
        sb.i_Busy_SideBand     = 1'b0;
        sb.i_falling_edge_busy = 1'b0;
        sb.i_Rx_SbMessage      = '0;
        sb.i_msg_valid         = 1'b0;
        sb.i_Rx_Payload        = '0;
        i_pattern_done         = 1'b0;
    endtask

    // One clock: sample at the falling edge, check new TX requests against
    // the expected queue, then drive the model's inputs for the next edge.
    task automatic tick();
        logic [MSG_W-1:0] got;
        logic [MSG_W-1:0] exp;
        bit               new_req;
        @(negedge clk);
        cyc++;
        new_req = sb.o_ValidOutDatat_Module && !prev_valid;
        prev_valid = sb.o_ValidOutDatat_Module;
        if (new_req) begin
            got = sb.o_TX_SbMessage;
            vec_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL tx_code: got %0d, no request expected (cycle %0d)", got, cyc);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    err_cnt++;
                    $display("FAIL tx_code: got %0d, expected %0d (cycle %0d)", got, exp, cyc);
                end
            end
            req_code = 4'(got);
        end

        sb.i_falling_edge_busy = 1'b0;
        sb.i_msg_valid         = 1'b0;
        sb.i_Rx_SbMessage      = '0;
        i_pattern_done         = 1'b0;

        if (new_req) begin
            sb.i_Busy_SideBand = 1'b1;
            busy_cnt = 2;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                sb.i_Busy_SideBand     = 1'b0;
                sb.i_falling_edge_busy = 1'b1;
                fall_cyc  = cyc;
                resp_cnt  = resp_delay;
                resp_code = req_code + 4'd1;
            end
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0 && !(drop_init_resp && resp_code == 4'd2)) begin
                sb.i_msg_valid = 1'b1;
                if (inject_wrong && resp_code == 4'd4) begin
                    inject_wrong      = 1'b0;
                    wrong_cyc         = cyc;
                    sb.i_Rx_SbMessage = MSG_W'(6);
                    resp_cnt          = 3;
                end else begin
                    sb.i_Rx_SbMessage = MSG_W'(resp_code);
                    if (resp_code == 4'd4) begin
                        sb.i_Rx_Payload = (pay_q.size() != 0) ? pay_q.pop_front() : '1;
                    end
                end
            end
        end

        if (o_pattern_en && !hold_pattern) begin
            pat_cnt++;
            if (pat_cnt == 2) i_pattern_done = 1'b1;
        end else begin
            pat_cnt = 0;
        end
    endtask

    task automatic run_until(input int budget, output bit ended, output bit errored);
        ended   = 1'b0;
        errored = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (o_module_end) begin
                ended = 1'b1;
                break;
            end
            if (o_train_error_req) begin
                errored = 1'b1;
                break;
            end
        end
    endtask

    // Drop i_start, confirm every request was seen and the DUT is back idle.
    task automatic finish_scenario(input string name);
        logic [7:0] outs;
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL %s_pending_tx: %0d requests missing, expected 0", name, exp_q.size());
        end
        i_start = 1'b0;
        tick();
        tick();
        outs = {o_pattern_en, o_module_end, o_train_error_req,
                sb.o_ValidOutDatat_Module, sb.o_TX_SbMessage};
        vec_cnt++;
        if (o_state !== ST_IDLE || outs !== 8'h00) begin
            err_cnt++;
            $display("FAIL %s_idle: state %0d outs %h, expected state 0 outs 00", name, o_state, outs);
        end
        reset_model();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] outs;
        rst_n = 1'b0;
        reset_model();
        tick();
        outs = {o_pattern_en, o_module_end, o_train_error_req,
                sb.o_ValidOutDatat_Module, sb.o_TX_SbMessage};
        vec_cnt++;
        if (outs !== 8'h00 || o_state !== ST_IDLE) begin
            err_cnt++;
            $display("FAIL reset_outputs: outs %h state %0d, expected 00 / 0", outs, o_state);
        end
        vec_cnt++;
        if (o_lane_mask !== 16'h0000 || o_retry_cnt !== 2'd0) begin
            err_cnt++;
            $display("FAIL reset_counters: mask %h retry %0d, expected 0000 / 0", o_lane_mask, o_retry_cnt);
        end
        rst_n = 1'b1;
        tick();
        tick();
        vec_cnt++;
        if (o_state !== ST_IDLE || sb.o_ValidOutDatat_Module !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_idle_no_start: state %0d valid %b, expected 0 / 0", o_state, sb.o_ValidOutDatat_Module);
        end
    endtask

    task automatic test_nominal();
        bit ended, errored;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd5);
        pay_q.push_back(16'hFFFF);
        i_start = 1'b1;
        run_until(300, ended, errored);
        vec_cnt++;
        if (!ended || errored) begin
            err_cnt++;
            $display("FAIL nominal_end: end %b error %b, expected 1 / 0", ended, errored);
        end
        vec_cnt++;
        if (o_retry_cnt !== 2'd0 || o_lane_mask !== 16'hFFFF) begin
            err_cnt++;
            $display("FAIL nominal_result: retry %0d mask %h, expected 0 / ffff", o_retry_cnt, o_lane_mask);
        end
        tick();
        vec_cnt++;
        if (o_module_end !== 1'b1) begin
            err_cnt++;
            $display("FAIL nominal_end_held: end %b, expected 1", o_module_end);
        end
        finish_scenario("nominal");
    endtask

    task automatic test_retry_pass();
        bit ended, errored;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd5);
        pay_q.push_back(16'h7FFF);
        pay_q.push_back(16'hFFFF);
        i_start = 1'b1;
        run_until(400, ended, errored);
        vec_cnt++;
        if (!ended || errored) begin
            err_cnt++;
            $display("FAIL retry_pass_end: end %b error %b, expected 1 / 0", ended, errored);
        end
        vec_cnt++;
        if (o_retry_cnt !== 2'd1 || o_lane_mask !== 16'hFFFF) begin
            err_cnt++;
            $display("FAIL retry_pass_result: retry %0d mask %h, expected 1 / ffff", o_retry_cnt, o_lane_mask);
        end
        finish_scenario("retry_pass");
    endtask

    task automatic test_retry_exhausted();
        bit ended, errored;
        logic [7:0] outs;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(4'd1);
            exp_q.push_back(4'd3);
            pay_q.push_back(16'h00FF);
        end
        i_start = 1'b1;
        run_until(500, ended, errored);
        vec_cnt++;
        if (!errored || ended) begin
            err_cnt++;
            $display("FAIL retry_exh_error: error %b end %b, expected 1 / 0", errored, ended);
        end
        vec_cnt++;
        if (o_retry_cnt !== 2'd2 || o_lane_mask !== 16'h00FF) begin
            err_cnt++;
            $display("FAIL retry_exh_result: retry %0d mask %h, expected 2 / 00ff", o_retry_cnt, o_lane_mask);
        end
        i_start = 1'b0;
        tick();
        outs = {o_pattern_en, o_module_end, o_train_error_req,
                sb.o_ValidOutDatat_Module, sb.o_TX_SbMessage};
        vec_cnt++;
        if (o_state !== ST_IDLE || outs !== 8'h00) begin
            err_cnt++;
            $display("FAIL retry_exh_release: state %0d outs %h, expected 0 / 00", o_state, outs);
        end
        vec_cnt++;
        if (o_retry_cnt !== 2'd2 || o_lane_mask !== 16'h00FF) begin
            err_cnt++;
            $display("FAIL retry_exh_hold: retry %0d mask %h, expected 2 / 00ff", o_retry_cnt, o_lane_mask);
        end
        finish_scenario("retry_exh");
    endtask

    task automatic test_timeout();
        bit ended, errored;
        int err_at;
        bit entry_ok;
        // No init_resp: the error must appear 16 cycles after the wait entry.
        drop_init_resp = 1'b1;
        exp_q.push_back(4'd1);
        i_start  = 1'b1;
        err_at   = -1;
        entry_ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (fall_cyc != 0 && cyc == fall_cyc + 1 && o_state === ST_WAIT_INIT) entry_ok = 1'b1;
            if (o_train_error_req) begin
                err_at = cyc;
                break;
            end
        end
        vec_cnt++;
        if (!entry_ok) begin
            err_cnt++;
            $display("FAIL timeout_entry: wait-state entry not seen after busy falling edge");
        end
        vec_cnt++;
        if (err_at != fall_cyc + 17) begin
            err_cnt++;
            $display("FAIL timeout_error_cycle: error after %0d cycles in wait, expected 16", err_at - fall_cyc - 1);
        end
        finish_scenario("timeout");

        // Every response lands in the last allowed cycle of its wait.
        resp_delay = 16;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd5);
        i_start = 1'b1;
        run_until(400, ended, errored);
        vec_cnt++;
        if (!ended || errored) begin
            err_cnt++;
            $display("FAIL timeout_last_cycle: end %b error %b, expected 1 / 0", ended, errored);
        end
        finish_scenario("timeout_edge");
    endtask

    task automatic test_unexpected_code();
        bit ended, errored;
        bit reached;
        inject_wrong = 1'b1;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd5);
        i_start = 1'b1;
        reached = 1'b0;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (wrong_cyc != 0 && cyc == wrong_cyc + 1) begin
                reached = 1'b1;
                break;
            end
        end
        vec_cnt++;
        if (!reached || o_state !== ST_WAIT_RESULT || o_module_end !== 1'b0 || o_train_error_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL unexpected_hold: reached %b state %0d end %b err %b, expected 1 / 6 / 0 / 0",
                     reached, o_state, o_module_end, o_train_error_req);
        end
        run_until(300, ended, errored);
        vec_cnt++;
        if (!ended || errored || o_lane_mask !== 16'hFFFF) begin
            err_cnt++;
            $display("FAIL unexpected_recover: end %b error %b mask %h, expected 1 / 0 / ffff",
                     ended, errored, o_lane_mask);
        end
        finish_scenario("unexpected");
    endtask

    task automatic test_abort();
        bit seen;
        bit stray;
        logic [7:0] outs;
        // Drop i_start while the pattern generator runs.
        hold_pattern = 1'b1;
        exp_q.push_back(4'd1);
        i_start = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (o_pattern_en) begin
                seen = 1'b1;
                break;
            end
        end
        vec_cnt++;
        if (!seen) begin
            err_cnt++;
            $display("FAIL abort_pattern_reached: pattern_en never 1, expected 1");
        end
        i_start = 1'b0;
        tick();
        vec_cnt++;
        if (o_pattern_en !== 1'b0 || o_state !== ST_IDLE) begin
            err_cnt++;
            $display("FAIL abort_pattern: pattern_en %b state %0d, expected 0 / 0", o_pattern_en, o_state);
        end
        stray = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (o_module_end || o_train_error_req) stray = 1'b1;
            tick();
        end
        vec_cnt++;
        if (stray) begin
            err_cnt++;
            $display("FAIL abort_no_pulse: end/error pulse seen %b, expected 0", stray);
        end
        finish_scenario("abort");

        // Asynchronous reset while a result request is outstanding.
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd3);
        i_start = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (sb.o_ValidOutDatat_Module && sb.o_TX_SbMessage == MSG_W'(3)) begin
                seen = 1'b1;
                break;
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        outs = {o_pattern_en, o_module_end, o_train_error_req,
                sb.o_ValidOutDatat_Module, sb.o_TX_SbMessage};
        vec_cnt++;
        if (!seen || outs !== 8'h00 || o_state !== ST_IDLE) begin
            err_cnt++;
            $display("FAIL async_reset: reached %b outs %h state %0d, expected 1 / 00 / 0", seen, outs, o_state);
        end
        vec_cnt++;
        if (o_lane_mask !== 16'h0000 || o_retry_cnt !== 2'd0) begin
            err_cnt++;
            $display("FAIL async_reset_counters: mask %h retry %0d, expected 0000 / 0", o_lane_mask, o_retry_cnt);
        end
        i_start = 1'b0;
        reset_model();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        test_reset();
        test_nominal();
        test_retry_pass();
        test_retry_exhausted();
        test_timeout();
        test_unexpected_code();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end
endmodule
